// File: rtl/if_fetch_pkg.sv
// Shared fetch-stage defines (ADDR_WIDTH, DATA_WIDTH, NOP, STOP, NOSTOP) and the fetch package.
// This package holds the FSM state encoding, the IF_NOP constant and the PC increment helper.
`ifndef IF_FETCH_DEFINES_SV
`define IF_FETCH_DEFINES_SV
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define NOP        32'h0000_0013
`define STOP       1'b1
`define NOSTOP     1'b0
`endif

package if_fetch_pkg;

    localparam int unsigned IF_AW = `ADDR_WIDTH;
    localparam int unsigned IF_DW = `DATA_WIDTH;
    localparam logic [IF_DW-1:0] IF_NOP = `NOP;

    typedef enum logic [1:0] {
        IF_REQ   = 2'd0,
        IF_WAIT  = 2'd1,
        IF_FLUSH = 2'd2,
        IF_IDLE  = 2'd3
    } if_state_e;

    // Sequential PC; wraps naturally at the address width.
    function automatic logic [IF_AW-1:0] if_pc_inc(input logic [IF_AW-1:0] pc);
        return pc + {{(IF_AW-3){1'b0}}, 3'd4};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: single-entry hold buffer in front of a request/grant/rvalid bus.
// Optional build macro IFETCH_ALIGN_CHECK_EN: word-align redirect targets and flag misalignment.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [`ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [5:0]             stall_i,
    input  logic                   jump_flag_i,
    input  logic [`ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                   int_flag_i,
    input  logic [`ADDR_WIDTH-1:0] int_addr_i,
    output logic                   ibus_req_o,
    output logic [`ADDR_WIDTH-1:0] ibus_addr_o,
    input  logic                   ibus_gnt_i,
    input  logic                   ibus_rvalid_i,
    input  logic [`DATA_WIDTH-1:0] ibus_rdata_i,
    output logic [`ADDR_WIDTH-1:0] inst_addr_o,
    output logic [`DATA_WIDTH-1:0] inst_o,
    output logic                   stallreq_o,
    output logic                   misalign_o
);

    if_state_e              state_q, state_d;
    logic [`ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [`DATA_WIDTH-1:0] inst_q, inst_d;
    logic [`ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
    logic                   misalign_q, misalign_d;

    logic                   redirect_s;
    logic [`ADDR_WIDTH-1:0] target_raw_s;
    logic [`ADDR_WIDTH-1:0] target_s;
    logic                   misalign_s;
    logic                   capture_s;
    logic                   req_block_s;
    logic                   unused_stall_s;

    assign unused_stall_s = ^stall_i[5:2];

    assign redirect_s   = int_flag_i | jump_flag_i;
    assign target_raw_s = int_flag_i ? int_addr_i : jump_addr_i;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign target_s   = {target_raw_s[`ADDR_WIDTH-1:2], 2'b00};
    assign misalign_s = redirect_s & (target_raw_s[1:0] != 2'b00);
`else
    assign target_s   = target_raw_s;
    assign misalign_s = 1'b0;
`endif

    // The single hold entry must not be refilled while IF/ID is still refusing it.
    assign req_block_s = hold_valid_q & (stall_i[1] == `STOP);
    assign capture_s   = (state_q == IF_WAIT) & ibus_rvalid_i & ~redirect_s;

    // Fetch FSM next state, PC update and bus request.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ibus_req_o = 1'b0;
        case (state_q)
            IF_REQ: begin
                if (req_block_s) begin
                    if (redirect_s) begin
                        pc_d = target_s;
                    end else begin
                        pc_d = pc_q;
                    end
                end else begin
                    ibus_req_o = 1'b1;
                    if (redirect_s) begin
                        pc_d    = target_s;
                        state_d = ibus_gnt_i ? IF_FLUSH : IF_REQ;
                    end else if (ibus_gnt_i) begin
                        state_d = IF_WAIT;
                    end else begin
                        state_d = IF_REQ;
                    end
                end
            end
            IF_WAIT: begin
                if (redirect_s) begin
                    pc_d    = target_s;
                    state_d = ibus_rvalid_i ? IF_REQ : IF_FLUSH;
                end else if (ibus_rvalid_i) begin
                    pc_d    = if_pc_inc(pc_q);
                    state_d = (stall_i[0] == `NOSTOP) ? IF_REQ : IF_IDLE;
                end else begin
                    state_d = IF_WAIT;
                end
            end
            IF_FLUSH: begin
                if (redirect_s) begin
                    pc_d = target_s;
                end else begin
                    pc_d = pc_q;
                end
                if (ibus_rvalid_i) begin
                    state_d = IF_REQ;
                end else begin
                    state_d = IF_FLUSH;
                end
            end
            IF_IDLE: begin
                if (redirect_s) begin
                    pc_d    = target_s;
                    state_d = IF_REQ;
                end else if ((stall_i[0] == `NOSTOP) && !hold_valid_q) begin
                    state_d = IF_REQ;
                end else begin
                    state_d = IF_IDLE;
                end
            end
            default: begin
                state_d = IF_REQ;
                pc_d    = RESET_PC;
            end
        endcase
    end

    // Hold buffer: redirect flushes it even over a same-cycle capture.
    always_comb begin
        hold_valid_d = hold_valid_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        misalign_d   = misalign_s;
        if (redirect_s) begin
            hold_valid_d = 1'b0;
            inst_d       = IF_NOP;
            inst_addr_d  = {`ADDR_WIDTH{1'b0}};
        end else if (capture_s) begin
            hold_valid_d = 1'b1;
            inst_d       = ibus_rdata_i;
            inst_addr_d  = pc_q;
        end else if (stall_i[1] == `NOSTOP) begin
            hold_valid_d = 1'b0;
            inst_d       = IF_NOP;
            inst_addr_d  = {`ADDR_WIDTH{1'b0}};
        end else begin
            hold_valid_d = hold_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IF_REQ;
            pc_q         <= RESET_PC;
            hold_valid_q <= 1'b0;
            inst_q       <= IF_NOP;
            inst_addr_q  <= {`ADDR_WIDTH{1'b0}};
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_valid_q <= hold_valid_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
            misalign_q   <= misalign_d;
        end
    end

    assign ibus_addr_o = (state_q == IF_REQ) ? pc_q : {`ADDR_WIDTH{1'b0}};
    assign inst_o      = inst_q;
    assign inst_addr_o = inst_addr_q;
    assign misalign_o  = misalign_q;
    assign stallreq_o  = ~hold_valid_q & ~redirect_s;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: zero-wait bus responder with switchable rvalid, hand-computed checks.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        int_flag;
    logic [31:0] int_addr;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        stallreq;
    logic        misalign;

    logic        gnt_en;
    logic        rv_en;
    logic        rdata_mode;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0000_0000;

    int n_checks = 0;
    int n_bad    = 0;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .stall_i       (stall),
        .jump_flag_i   (jump_flag),
        .jump_addr_i   (jump_addr),
        .int_flag_i    (int_flag),
        .int_addr_i    (int_addr),
        .ibus_req_o    (ibus_req),
        .ibus_addr_o   (ibus_addr),
        .ibus_gnt_i    (ibus_gnt),
        .ibus_rvalid_i (ibus_rvalid),
        .ibus_rdata_i  (ibus_rdata),
        .inst_addr_o   (inst_addr),
        .inst_o        (inst),
        .stallreq_o    (stallreq),
        .misalign_o    (misalign)
    );

    // Bus: grant in the request cycle, data the cycle after (unless rvalid is held off).
    assign ibus_gnt    = ibus_req & gnt_en;
    assign ibus_rvalid = pend & rv_en;
    assign ibus_rdata  = rdata_mode ? {pend_addr[23:0], 8'h13} : 32'h0000_0013;

    always @(posedge clk) begin
        if (ibus_rvalid) pend <= 1'b0;
        if (ibus_req && ibus_gnt) begin
            pend      <= 1'b1;
            pend_addr <= ibus_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; stall = 6'd0; jump_flag = 1'b0; jump_addr = 32'd0;
        int_flag = 1'b0; int_addr = 32'd0; gnt_en = 1'b1; rv_en = 1'b1; rdata_mode = 1'b0;
        step(); step();
        check_eq("rst_req",      {31'd0, ibus_req}, 32'd1);
        check_eq("rst_addr",     ibus_addr, 32'd0);
        check_eq("rst_inst",     inst, NOP_W);
        check_eq("rst_iaddr",    inst_addr, 32'd0);
        check_eq("rst_stallreq", {31'd0, stallreq}, 32'd1);
        check_eq("rst_misalign", {31'd0, misalign}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("f0_req",  {31'd0, ibus_req}, 32'd1);
        check_eq("f0_addr", ibus_addr, 32'd0);
        step();
        check_eq("wait0_req",      {31'd0, ibus_req}, 32'd0);
        check_eq("wait0_stallreq", {31'd0, stallreq}, 32'd1);
        check_eq("wait0_inst",     inst, NOP_W);
        step();
        check_eq("cap0_iaddr",    inst_addr, 32'd0);
        check_eq("cap0_inst",     inst, 32'h0000_0013);
        check_eq("cap0_stallreq", {31'd0, stallreq}, 32'd0);
        check_eq("f4_addr",       ibus_addr, 32'd4);
        step();
        check_eq("wait4_stallreq", {31'd0, stallreq}, 32'd1);
        check_eq("wait4_inst",     inst, NOP_W);
        step();
        check_eq("cap4_iaddr",    inst_addr, 32'd4);
        check_eq("cap4_inst",     inst, 32'h0000_0013);
        check_eq("cap4_stallreq", {31'd0, stallreq}, 32'd0);

        // Jump while the fetch of 8 is in flight.
        step();
        rv_en = 1'b0; jump_flag = 1'b1; jump_addr = 32'h0000_0100;
        #1;
        check_eq("jmp_stallreq", {31'd0, stallreq}, 32'd0);
        step();
        jump_flag = 1'b0; rv_en = 1'b1;
        #1;
        check_eq("flush_req",   {31'd0, ibus_req}, 32'd0);
        check_eq("flush_iaddr", inst_addr, 32'd0);
        step();
        rdata_mode = 1'b1;
        check_eq("j100_req",   {31'd0, ibus_req}, 32'd1);
        check_eq("j100_addr",  ibus_addr, 32'h0000_0100);
        check_eq("j100_iaddr", inst_addr, 32'd0);
        step();
        check_eq("j100w_iaddr", inst_addr, 32'd0);
        step();
        check_eq("cap100_iaddr", inst_addr, 32'h0000_0100);
        check_eq("cap100_inst",  inst, 32'h0001_0013);

        // Interrupt and jump together: interrupt wins.
        int_flag = 1'b1; int_addr = 32'h0000_0080; jump_flag = 1'b1; jump_addr = 32'h0000_0200;
        step();
        int_flag = 1'b0; jump_flag = 1'b0;
        #1;
        check_eq("prio_inst", inst, NOP_W);
        check_eq("prio_req",  {31'd0, ibus_req}, 32'd0);
        step();
        check_eq("prio_req2", {31'd0, ibus_req}, 32'd1);
        check_eq("prio_addr", ibus_addr, 32'h0000_0080);
        step(); step();
        check_eq("cap80_iaddr", inst_addr, 32'h0000_0080);
        check_eq("cap80_inst",  inst, 32'h0000_8013);

        // IF/ID stall with a full hold buffer: no request, stable output.
        stall = 6'b000011;
        #1;
        check_eq("hold_req0", {31'd0, ibus_req}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("hold_req",   {31'd0, ibus_req}, 32'd0);
            check_eq("hold_inst",  inst, 32'h0000_8013);
            check_eq("hold_iaddr", inst_addr, 32'h0000_0080);
        end
        stall = 6'd0;
        #1;
        check_eq("rel_req",  {31'd0, ibus_req}, 32'd1);
        check_eq("rel_addr", ibus_addr, 32'h0000_0084);

        // PC stall on capture parks the FSM in IDLE.
        step();
        stall = 6'b000001;
        check_eq("w84_inst", inst, NOP_W);
        step();
        stall = 6'd0;
        check_eq("cap84_iaddr", inst_addr, 32'h0000_0084);
        check_eq("idle_req",    {31'd0, ibus_req}, 32'd0);
        step();
        check_eq("idle_req2", {31'd0, ibus_req}, 32'd0);
        check_eq("idle_inst", inst, NOP_W);
        step();
        check_eq("f88_req",  {31'd0, ibus_req}, 32'd1);
        check_eq("f88_addr", ibus_addr, 32'h0000_0088);

        // Misaligned redirect target.
        jump_flag = 1'b1; jump_addr = 32'h0000_0102;
        step();
        jump_flag = 1'b0;
        #1;
`ifdef IFETCH_ALIGN_CHECK_EN
        check_eq("mis_pulse", {31'd0, misalign}, 32'd1);
`else
        check_eq("mis_pulse", {31'd0, misalign}, 32'd0);
`endif
        step();
        check_eq("mis_clear", {31'd0, misalign}, 32'd0);
        check_eq("mis_req",   {31'd0, ibus_req}, 32'd1);
`ifdef IFETCH_ALIGN_CHECK_EN
        check_eq("mis_addr",  ibus_addr, 32'h0000_0100);
`else
        check_eq("mis_addr",  ibus_addr, 32'h0000_0102);
`endif

        // Reset while a fetch is outstanding.
        step();
        check_eq("rw_req", {31'd0, ibus_req}, 32'd0);
        rst = 1'b1;
        #1;
        check_eq("rw_req2",     {31'd0, ibus_req}, 32'd1);
        check_eq("rw_addr",     ibus_addr, 32'd0);
        check_eq("rw_inst",     inst, NOP_W);
        check_eq("rw_iaddr",    inst_addr, 32'd0);
        check_eq("rw_stallreq", {31'd0, stallreq}, 32'd1);
        check_eq("rw_misalign", {31'd0, misalign}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_eq("rr_req",  {31'd0, ibus_req}, 32'd1);
        check_eq("rr_addr", ibus_addr, 32'd0);
        step();
        check_eq("late_rv_inst",     inst, NOP_W);
        check_eq("late_rv_stallreq", {31'd0, stallreq}, 32'd1);
        step();
        check_eq("rcap_iaddr", inst_addr, 32'd0);
        check_eq("rcap_inst",  inst, 32'h0000_0013);

        // PC wrap at the top of the address space.
        jump_flag = 1'b1; jump_addr = 32'hFFFF_FFFC;
        step();
        jump_flag = 1'b0;
        step();
        check_eq("top_addr", ibus_addr, 32'hFFFF_FFFC);
        step(); step();
        check_eq("top_iaddr", inst_addr, 32'hFFFF_FFFC);
        check_eq("top_inst",  inst, 32'hFFFF_FC13);
        check_eq("wrap_req",  {31'd0, ibus_req}, 32'd1);
        check_eq("wrap_addr", ibus_addr, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
